// File: rtl/tag_frame_collector.sv
// Tag reply frame collector: hunts for a sync word in the decoded reply bit stream,
// collects a runtime-sized payload and checks the EPC Gen2 CRC-16 residue.
module tag_frame_collector #(
  parameter int                  SYNC_LEN    = 6,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 6'b101011,
  parameter int                  MAX_BITS    = 128,
  parameter int                  TIMEOUT_CYC = 4096,
  parameter int                  LEN_W       = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_dat,
  input  logic                in_vld,
  input  logic                start,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic                crc_chk,
  output logic                busy,
  output logic [MAX_BITS-1:0] out_data,
  output logic [LEN_W-1:0]    out_len,
  output logic                out_vld,
  output logic                out_crc_ok,
  output logic                out_timeout
);

  localparam int FILL_W = $clog2(SYNC_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC);

  localparam logic [15:0]       CRC_PRESET  = 16'hFFFF;
  localparam logic [15:0]       CRC_POLY    = 16'h1021;
  localparam logic [15:0]       CRC_RESIDUE = 16'h1D0F;
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(SYNC_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX     = LEN_W'(MAX_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_COLLECT
  } state_t;

  typedef logic [SYNC_LEN-1:0] sync_t;

  state_t              state;
  sync_t               sync_sr;
  logic [FILL_W-1:0]   sync_fill;
  logic [MAX_BITS-1:0] payload;
  logic [LEN_W-1:0]    bit_cnt;
  logic [LEN_W-1:0]    len_q;
  logic                crc_en;
  logic [15:0]         crc;
  logic [IDLE_W-1:0]   idle_cnt;

  sync_t               sync_next;
  logic [FILL_W-1:0]   fill_next;
  logic                sync_hit;
  logic [MAX_BITS-1:0] payload_next;
  logic [LEN_W-1:0]    cnt_next;
  logic [15:0]         crc_next;
  logic                timeout_hit;
  logic [LEN_W-1:0]    len_clamped;

  logic                done;
  logic [MAX_BITS-1:0] fin_data;
  logic [LEN_W-1:0]    fin_len;
  logic                fin_ok;
  logic                fin_to;

  // One bit of the Gen2 CRC-16 register, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  assign len_clamped  = (frame_len > LEN_MAX) ? LEN_MAX : frame_len;
  assign sync_next    = sync_t'({sync_sr, in_dat});
  assign fill_next    = (sync_fill == FILL_FULL) ? sync_fill : sync_fill + 1'b1;
  assign sync_hit     = (fill_next == FILL_FULL) && (sync_next == SYNC_WORD);
  assign payload_next = {payload[MAX_BITS-2:0], in_dat};
  assign cnt_next     = bit_cnt + 1'b1;
  assign crc_next     = crc_en ? crc_step(crc, in_dat) : crc;
  assign timeout_hit  = !in_vld && (idle_cnt == IDLE_LAST);

  // Completion decision and the values it publishes; a strobe on the
  // threshold cycle keeps the frame alive because timeout_hit needs !in_vld.
  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    done     = 1'b0;
    fin_data = payload_next;
    fin_len  = cnt_next;
    fin_ok   = (crc_next == CRC_RESIDUE) || !crc_en;
    fin_to   = 1'b0;
    case (state)
      S_HUNT: begin
        if (in_vld && sync_hit && (len_q == '0)) begin
          done     = 1'b1;
          fin_data = payload;
          fin_len  = '0;
          fin_ok   = !crc_en;
        end else if (timeout_hit) begin
          done     = 1'b1;
          fin_data = payload;
          fin_len  = bit_cnt;
          fin_ok   = 1'b0;
          fin_to   = 1'b1;
        end
      end
      S_COLLECT: begin
        if (in_vld && (cnt_next == len_q)) begin
          done = 1'b1;
        end else if (timeout_hit) begin
          done     = 1'b1;
          fin_data = payload;
          fin_len  = bit_cnt;
          fin_ok   = 1'b0;
          fin_to   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      sync_sr     <= '0;
      sync_fill   <= '0;
      payload     <= '0;
      bit_cnt     <= '0;
      len_q       <= '0;
      crc_en      <= 1'b0;
      crc         <= CRC_PRESET;
      idle_cnt    <= '0;
      busy        <= 1'b0;
      out_data    <= '0;
      out_len     <= '0;
      out_vld     <= 1'b0;
      out_crc_ok  <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      if (start) begin
        // Arming wins over everything, including a frame that would complete now.
        state     <= S_HUNT;
        busy      <= 1'b1;
        len_q     <= len_clamped;
        crc_en    <= crc_chk;
        sync_sr   <= '0;
        sync_fill <= '0;
        payload   <= '0;
        bit_cnt   <= '0;
        idle_cnt  <= '0;
        crc       <= CRC_PRESET;
      end else begin
        if (state != S_IDLE) begin
          idle_cnt <= in_vld ? '0 : idle_cnt + 1'b1;
        end
        case (state)
          S_HUNT: begin
            if (in_vld) begin
              sync_sr   <= sync_next;
              sync_fill <= fill_next;
              if (sync_hit) begin
                state   <= S_COLLECT;
                bit_cnt <= '0;
              end
            end
          end
          S_COLLECT: begin
            if (in_vld) begin
              payload <= payload_next;
              bit_cnt <= cnt_next;
              crc     <= crc_next;
            end
          end
          default: ;
        endcase
        if (done) begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          out_vld     <= 1'b1;
          out_data    <= fin_data;
          out_len     <= fin_len;
          out_crc_ok  <= fin_ok;
          out_timeout <= fin_to;
        end
      end
    end
  end

endmodule

// File: tb/tb_tag_frame_collector.sv
// Self-checking bench for tag_frame_collector: directed frames plus randomized
// frames scored against a bit-list reference model.
`timescale 1ns/1ps
module tb_tag_frame_collector;

  localparam int                  SYNC_LEN    = 6;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD   = 6'b101011;
  localparam int                  MAX_BITS    = 128;
  localparam int                  TIMEOUT_CYC = 64;
  localparam int                  LEN_W       = $clog2(MAX_BITS + 1);

  typedef logic [MAX_BITS-1:0] word_t;
  typedef bit bitq_t[$];
  typedef struct { word_t data; int len; bit ok; bit to; int used; } exp_t;
  typedef struct { word_t data; int len; bit ok; bit to; bit busy; int cyc; } obs_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_dat = 1'b0;
  logic             in_vld = 1'b0;
  logic             start = 1'b0;
  logic             crc_chk = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             busy, out_vld, out_crc_ok, out_timeout;
  word_t            out_data;
  logic [LEN_W-1:0] out_len;

  int   cyc = 0;
  int   last_act = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  obs_t obs_q[$];

  tag_frame_collector #(
    .SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC_WORD), .MAX_BITS(MAX_BITS),
    .TIMEOUT_CYC(TIMEOUT_CYC), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_vld(in_vld), .start(start),
    .frame_len(frame_len), .crc_chk(crc_chk), .busy(busy), .out_data(out_data),
    .out_len(out_len), .out_vld(out_vld), .out_crc_ok(out_crc_ok), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (out_vld === 1'b1) begin
      o.data = out_data;
      o.len  = int'(out_len);
      o.ok   = out_crc_ok;
      o.to   = out_timeout;
      o.busy = busy;
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] crc16(input bitq_t q);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) c = (c << 1) ^ (((c[15] ^ q[i]) != 1'b0) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  function automatic bitq_t push_bits(input bitq_t q, input logic [31:0] v, input int n);
    bitq_t r = q;
    for (int i = n - 1; i >= 0; i--) r.push_back(v[i]);
    return r;
  endfunction

  function automatic bitq_t rand_bits(input bitq_t q, input int n);
    bitq_t r = q;
    for (int i = 0; i < n; i++) r.push_back(1'($urandom_range(0, 1)));
    return r;
  endfunction

  // Reference: find the first sync window in the received bits, take the next
  // len bits; too few bits means the stream stalls into a timeout.
  function automatic exp_t model(input bitq_t q, input int flen, input bit chk);
    exp_t        e;
    int          l, s, n;
    bit          m;
    logic [15:0] c;
    logic [SYNC_LEN-1:0] pat = SYNC_WORD;
    e.data = '0; e.len = 0; e.ok = 0; e.to = 0; e.used = q.size();
    l = (flen > MAX_BITS) ? MAX_BITS : flen;
    s = -1;
    for (int k = SYNC_LEN - 1; k < q.size() && s < 0; k++) begin
      m = 1;
      for (int j = 0; j < SYNC_LEN; j++)
        if (q[k - SYNC_LEN + 1 + j] != pat[SYNC_LEN - 1 - j]) m = 0;
      if (m) s = k;
    end
    if (s < 0) begin
      e.to = 1;
      return e;
    end
    if (l == 0) begin
      e.ok = !chk;
      e.used = s + 1;
      return e;
    end
    c = 16'hFFFF;
    n = 0;
    for (int k = s + 1; k < q.size() && n < l; k++) begin
      e.data = (e.data << 1) | word_t'(q[k]);
      c = (c << 1) ^ (((c[15] ^ q[k]) != 1'b0) ? 16'h1021 : 16'h0000);
      n++;
      e.used = k + 1;
    end
    e.len = n;
    if (n == l) e.ok = !chk || (c == 16'h1D0F);
    else begin
      e.to = 1;
      e.used = q.size();
    end
    return e;
  endfunction

  task automatic drive(input bit v, input bit b);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_vld = v;
    in_dat = b;
    if (v) last_act = cyc;
  endtask

  task automatic arm(input int flen, input bit chk, input bit v, input bit b);
    @(posedge clk);
    #1;
    start = 1'b1;
    frame_len = LEN_W'(flen);
    crc_chk = chk;
    in_vld = v;
    in_dat = b;
    last_act = cyc;
  endtask

  task automatic send_bits(input bitq_t q, input int max_gap);
    foreach (q[i]) begin
      drive(1'b1, q[i]);
      if (max_gap > 0 && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, max_gap)) drive(1'b0, 1'b0);
    end
  endtask

  task automatic wait_vld(output bit got);
    int n = 0;
    while (obs_q.size() == 0 && n < TIMEOUT_CYC + 16) begin
      drive(1'b0, 1'b0);
      n++;
    end
    got = (obs_q.size() != 0);
  endtask

  task automatic run_frame(input string tag, input int flen, input bit chk, input bit v0,
                           input bit b0, input bitq_t bits, input int max_gap, output obs_t o);
    exp_t e;
    bit   got;
    e = model(bits, flen, chk);
    o.data = '0; o.len = 0; o.ok = 0; o.to = 0; o.busy = 0; o.cyc = 0;
    arm(flen, chk, v0, b0);
    send_bits(bits, max_gap);
    wait_vld(got);
    check({tag, "_seen"}, word_t'(got), word_t'(1));
    if (got) begin
      o = obs_q.pop_front();
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_len"}, word_t'(o.len), word_t'(e.len));
      check({tag, "_crc_ok"}, word_t'(o.ok), word_t'(e.ok));
      check({tag, "_timeout"}, word_t'(o.to), word_t'(e.to));
      check({tag, "_busy"}, word_t'(o.busy), word_t'(0));
      if (e.used == bits.size())
        check({tag, "_lat"}, word_t'(o.cyc),
              word_t'(e.to ? last_act + 1 + TIMEOUT_CYC : last_act + 1));
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check({tag, "_single"}, word_t'(obs_q.size()), word_t'(0));
    obs_q.delete();
  endtask

  initial begin
    bitq_t       none, sync_q, q, p;
    obs_t        o;
    logic [15:0] c;
    int          flen, leff, nb;
    bit          chk;

    sync_q = push_bits(none, 32'(SYNC_WORD), SYNC_LEN);
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", word_t'(busy), word_t'(0));
    check("rst_vld", word_t'(out_vld), word_t'(0));
    check("rst_data", out_data, word_t'(0));
    check("rst_len", word_t'(out_len), word_t'(0));
    check("rst_ok", word_t'(out_crc_ok), word_t'(0));
    check("rst_to", word_t'(out_timeout), word_t'(0));
    @(negedge clk) rst = 1'b1;

    // busy rises the cycle after start
    arm(8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("busy_pre", word_t'(busy), word_t'(0));
    drive(1'b0, 1'b0);
    @(negedge clk);
    check("busy_rise", word_t'(busy), word_t'(1));

    q = push_bits(sync_q, 32'hA5C3, 16);
    run_frame("basic", 16, 1'b0, 1'b0, 1'b0, q, 0, o);
    check("basic_word", o.data, word_t'(16'hA5C3));
    check("basic_n", word_t'(o.len), word_t'(16));

    q = push_bits(none, 32'b1010101011, 10);
    q = push_bits(q, 32'h3C, 8);
    run_frame("false_sync", 8, 1'b0, 1'b0, 1'b0, q, 0, o);
    check("false_sync_word", o.data, word_t'(8'h3C));

    p = push_bits(none, 32'hA5C3, 16);
    c = ~crc16(p);
    q = push_bits(sync_q, 32'hA5C3, 16);
    q = push_bits(q, 32'(c), 16);
    run_frame("crc_good", 32, 1'b1, 1'b0, 1'b0, q, 0, o);
    check("crc_good_flag", word_t'(o.ok), word_t'(1));
    q = push_bits(sync_q, 32'hA4C3, 16);
    q = push_bits(q, 32'(c), 16);
    run_frame("crc_bad", 32, 1'b1, 1'b0, 1'b0, q, 0, o);
    check("crc_bad_flag", word_t'(o.ok), word_t'(0));

    // restart mid-COLLECT; the bit arriving with start must be dropped
    arm(16, 1'b0, 1'b0, 1'b0);
    send_bits(push_bits(sync_q, 32'b1011, 4), 0);
    check("restart_quiet", word_t'(obs_q.size()), word_t'(0));
    q = push_bits(none, 32'b01011, 5);
    q = push_bits(q, 32'(SYNC_WORD), SYNC_LEN);
    q = push_bits(q, 32'hA5C3, 16);
    run_frame("restart", 16, 1'b0, 1'b1, 1'b1, q, 0, o);
    check("restart_word", o.data, word_t'(16'hA5C3));

    // asynchronous reset mid-frame
    arm(16, 1'b0, 1'b0, 1'b0);
    send_bits(push_bits(sync_q, 32'b0110, 4), 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", word_t'(busy), word_t'(0));
    check("mid_rst_data", out_data, word_t'(0));
    check("mid_rst_len", word_t'(out_len), word_t'(0));
    check("mid_rst_ok", word_t'(out_crc_ok), word_t'(0));
    in_vld = 1'b0;
    @(negedge clk) rst = 1'b1;
    check("mid_rst_quiet", word_t'(obs_q.size()), word_t'(0));
    q = push_bits(sync_q, 32'h5A3C, 16);
    run_frame("post_rst", 16, 1'b0, 1'b0, 1'b0, q, 0, o);

    q = rand_bits(sync_q, 5);
    run_frame("to_collect", 16, 1'b0, 1'b0, 1'b0, q, 0, o);
    check("to_collect_n", word_t'(o.len), word_t'(5));
    check("to_collect_flag", word_t'(o.to), word_t'(1));
    run_frame("to_hunt", 16, 1'b0, 1'b0, 1'b0, none, 0, o);
    check("to_hunt_n", word_t'(o.len), word_t'(0));

    run_frame("len0", 0, 1'b0, 1'b0, 1'b0, sync_q, 0, o);
    check("len0_ok", word_t'(o.ok), word_t'(1));
    run_frame("len0_chk", 0, 1'b1, 1'b0, 1'b0, sync_q, 0, o);
    check("len0_chk_ok", word_t'(o.ok), word_t'(0));

    q = rand_bits(sync_q, MAX_BITS + 2);
    run_frame("clamp", 200, 1'b0, 1'b0, 1'b0, q, 0, o);
    check("clamp_n", word_t'(o.len), word_t'(MAX_BITS));

    for (int t = 0; t < 30; t++) begin
      flen = $urandom_range(0, 140);
      chk  = 1'($urandom_range(0, 1));
      leff = (flen > MAX_BITS) ? MAX_BITS : flen;
      q = rand_bits(none, $urandom_range(0, 8));
      q = push_bits(q, 32'(SYNC_WORD), SYNC_LEN);
      nb = leff;
      if (leff > 0 && $urandom_range(0, 7) == 0) nb = $urandom_range(0, leff - 1);
      if (chk && nb == leff && leff >= 16 && $urandom_range(0, 1) == 1) begin
        p = rand_bits(none, leff - 16);
        c = ~crc16(p);
        foreach (p[i]) q.push_back(p[i]);
        q = push_bits(q, 32'(c), 16);
      end else begin
        q = rand_bits(q, nb);
      end
      run_frame("rand", flen, chk, 1'b0, 1'b0, q, $urandom_range(0, 3), o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tag_frame_collector.md
# tag_frame_collector

Downstream of `bits_detector` in the reader receive path. It consumes the decoded tag-reply bit stream (`out_dat`/`out_vld`) and, after an arming `start` pulse, hunts for a configurable sync word. It then collects a runtime-specified number of payload bits and optionally checks the EPC Gen2 CRC-16. It delivers the frame as a parallel word with status flags to the reader control logic, and aborts with a timeout flag if the bit stream stalls.

## Interface
- `SYNC_LEN`, 6: sync word length in bits (1..16).
- `SYNC_WORD`, 6'b101011: expected sync pattern; MSB is the first bit on air.
- `MAX_BITS`, 128: payload register width; maximum frame length.
- `TIMEOUT_CYC`, 4096: idle clock cycles without `in_vld` before abort (≥2).
- `LEN_W`, $clog2(MAX_BITS+1): width of length fields.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_dat`  in  1  decoded bit from `bits_detector`.
- `in_vld`  in  1  `in_dat` qualifier, single-cycle strobes.
- `start`  in  1  arm pulse; samples `frame_len` and `crc_chk`.
- `frame_len`  in  LEN_W  payload bits expected, including the CRC field.
- `crc_chk`  in  1  enable CRC-16 residue check.
- `busy`  out  1  high in HUNT/COLLECT.
- `out_data`  out  MAX_BITS  payload, right-aligned; the last bit received is at bit 0.
- `out_len`  out  LEN_W  number of payload bits actually captured.
- `out_vld`  out  1  one-cycle completion pulse.
- `out_crc_ok`  out  1  CRC residue good, or `crc_chk`=0.
- `out_timeout`  out  1  frame ended by timeout.

## Operation
- **States:** IDLE, HUNT, COLLECT.
- **IDLE:** `busy`=0; `in_vld` ignored.
  - `start` → HUNT.
  - Latch `frame_len`, clamped to MAX_BITS. Latch `crc_chk`.
  - Clear the sync shift register, sync fill count, payload, bit count and idle counter.
  - Preset CRC to 16'hFFFF.
- **HUNT:**
  - Each `in_vld` shifts `in_dat` into the SYNC_LEN-bit shift register (LSB in) and increments fill count (saturating at SYNC_LEN).
  - Match requires fill = SYNC_LEN and the register equals SYNC_WORD after the shift. Only bits received since `start` count.
  - On match → COLLECT; bit count = 0.
  - If latched length = 0, go directly to completion on the match edge. `out_len`=0; `out_crc_ok` = !crc_chk.
- **COLLECT:**
  - Each `in_vld` left-shifts `in_dat` into the payload register and increments bit count.
  - If CRC is enabled, update the CRC per bit: poly 16'h1021, MSB-first, feedback = crc[15]^in_dat.
  - When bit count reaches the latched length → completion.
- **Completion:** `out_vld`=1 for one cycle. `out_len` = bits captured; `out_timeout`=0; `out_crc_ok` = (crc == 16'h1D0F) || !crc_chk. Then → IDLE.
- **Timeout:**
  - In HUNT/COLLECT, the idle counter increments on every cycle without `in_vld` and clears on `in_vld`.
  - Reaching TIMEOUT_CYC-1 with no `in_vld` → `out_vld`=1, `out_timeout`=1, `out_crc_ok`=0, `out_len` = bits captured so far (0 if in HUNT) → IDLE.
  - An `in_vld` in the same cycle as the timeout threshold wins: the bit is accepted and the counter clears.
- **Restart:** `start` while busy aborts the current frame without `out_vld` and re-arms as from IDLE. A coincident `in_vld` is discarded.
- `out_data`, `out_len`, `out_crc_ok` and `out_timeout` hold their values until the next completion.
- **Reset:** all outputs 0, state IDLE. Asynchronous assertion mid-frame discards everything.

## Timing
- All outputs are registered.
- `out_vld` is high in the cycle immediately after the edge that samples the final `in_vld` bit (latency 1). The data/flag outputs update on that same edge.
- `busy` rises the cycle after `start` and falls in the same cycle `out_vld` rises.
- A new `start` is accepted in the `out_vld` cycle.
- `in_vld` may arrive on consecutive cycles; every strobe must be consumed with no gaps required.
- The sync match, payload shift and CRC update are single-cycle operations; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic frame:** `start`, frame_len=16, crc_chk=0; bits 1,0,1,0,1,1 then 0xA5C3 MSB-first → one `out_vld`; out_data[15:0]=16'hA5C3, out_len=16, out_crc_ok=1, out_timeout=0.
- **False-sync rejection:** stream 1,0,1,0,1,0,1,0,1,1 followed by 8 bits 0x3C, frame_len=8 → sync taken at bit 10; out_data[7:0]=8'h3C.
- **CRC:** 16-bit word 0xA5C3 followed by its Gen2 CRC-16 (ones' complement of the preset-FFFF register), frame_len=32, crc_chk=1 → out_crc_ok=1. Repeat with one payload bit flipped → out_crc_ok=0.
- **Timeout:** sync found, then 5 of 16 bits sent, then TIMEOUT_CYC idle cycles → `out_vld` with out_timeout=1, out_len=5. Also run with no sync at all → out_len=0.
- **Restart/reset:** `start` mid-COLLECT → no `out_vld`, and the next frame decodes correctly. Assert `rst` low mid-frame → all outputs 0 immediately and `busy`=0.
- **Edges:** frame_len=0 → `out_vld` on the sync edge. frame_len=200 → clamped to 128. Back-to-back `in_vld` every cycle → no dropped bits.
